// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_rx
// Purpose  : PS/2 device-side receiver. Detects a host request-to-send,
//            generates the device clock (one pulse per bit), shifts in the
//            start/data/parity/stop bits, drives the ACK bit and reports
//            the received byte. Host clock-hold cancels a frame.
// Ports    : clock_quarter - sole clock, 4x the PS/2 bit rate
//            reset         - asynchronous, active-low
//            inhibit       - transmitter owns the bus; blocks RTS detection
//            buffer        - last byte received with good parity
//            valid         - one-cycle pulse when buffer is updated
//            parity_err    - one-cycle pulse on bad parity or framing error
//            abort         - one-cycle pulse when the host cancels a frame
//            ready         - high exactly while in IDLE
//            PS2_CLK       - open-drain bus clock (0 or z)
//            PS2_DAT       - open-drain bus data  (0 or z)
// Revision : 1.0 - initial release
// ============================================================================
module ps2_rx #(
  parameter int RTS_QUARTERS = 2
) (
  input  logic       clock_quarter,
  input  logic       reset,
  input  logic       inhibit,
  output logic [7:0] buffer,
  output logic       valid,
  output logic       parity_err,
  output logic       abort,
  output logic       ready,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT
);

  // The RTS counter only has to hold values up to RTS_QUARTERS-1: the
  // qualifying quarter that would reach RTS_QUARTERS moves us to START.
  localparam int             RTS_W    = (RTS_QUARTERS > 1) ? $clog2(RTS_QUARTERS) : 1;
  localparam logic [RTS_W-1:0] RTS_LAST = RTS_W'(RTS_QUARTERS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_ACK    = 3'd5;
  localparam logic [2:0] S_DELAY  = 3'd6;

  logic [2:0]       state_q,   state_d;
  logic [1:0]       bit_cnt_q, bit_cnt_d;
  logic [RTS_W-1:0] rts_cnt_q, rts_cnt_d;
  logic [7:0]       shreg_q,   shreg_d;
  logic [2:0]       idx_q,     idx_d;
  logic             par_ok_q,  par_ok_d;
  logic [7:0]       buffer_q,  buffer_d;
  logic             valid_q,   valid_d;
  logic             perr_q,    perr_d;
  logic             abort_q,   abort_d;

  logic w_clk_in;
  logic w_dat_in;
  logic w_bit_end;
  logic w_in_frame;
  logic w_clk_low;
  logic w_dat_low;

  assign w_clk_in   = PS2_CLK;
  assign w_dat_in   = PS2_DAT;
  assign w_bit_end  = (bit_cnt_q == 2'd3);
  assign w_in_frame = (state_q inside {S_START, S_DATA, S_PARITY, S_STOP, S_ACK});

  // --------------------------------------------------------------------------
  // State register and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_quarter or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 2'd0;
      rts_cnt_q <= '0;
      shreg_q   <= 8'h00;
      idx_q     <= 3'd0;
      par_ok_q  <= 1'b0;
      buffer_q  <= 8'h00;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rts_cnt_q <= rts_cnt_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      par_ok_q  <= par_ok_d;
      buffer_q  <= buffer_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      abort_q   <= abort_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Bus lines are only sampled at bit_cnt=3, i.e. after
  // our released clock has risen again.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = 2'd0;
    rts_cnt_d = rts_cnt_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    par_ok_d  = par_ok_q;
    buffer_d  = buffer_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    abort_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!inhibit && w_clk_in && !w_dat_in) begin
          if (rts_cnt_q == RTS_LAST) begin
            state_d   = S_START;
            rts_cnt_d = '0;
          end else begin
            rts_cnt_d = rts_cnt_q + 1'b1;
          end
        end else begin
          rts_cnt_d = '0;
        end
      end

      S_START, S_DATA, S_PARITY, S_STOP, S_ACK: begin
        if (w_bit_end) begin
          if (!w_clk_in) begin
            // Host is holding the clock low: cancel, regardless of bit.
            state_d = S_DELAY;
            abort_d = 1'b1;
          end else begin
            case (state_q)
              S_START: begin
                idx_d   = 3'd0;
                state_d = w_dat_in ? S_DELAY : S_DATA;
              end
              S_DATA: begin
                shreg_d = {w_dat_in, shreg_q[7:1]};
                idx_d   = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                  state_d = S_PARITY;
                end
              end
              S_PARITY: begin
                par_ok_d = ^{shreg_q, w_dat_in};
                state_d  = S_STOP;
              end
              S_STOP: begin
                if (w_dat_in) begin
                  state_d = S_ACK;
                end else begin
                  state_d = S_DELAY;
                  perr_d  = 1'b1;
                end
              end
              default: begin // S_ACK
                state_d = S_DELAY;
                if (par_ok_q) begin
                  valid_d  = 1'b1;
                  buffer_d = shreg_q;
                end else begin
                  perr_d   = 1'b1;
                end
              end
            endcase
          end
        end
      end

      S_DELAY: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Bit transitions only happen at bit_cnt=3, so the +1 wraps to 0 on
    // entry to the following bit; any entry from IDLE starts at 0.
    if (w_in_frame && (state_d inside {S_START, S_DATA, S_PARITY, S_STOP, S_ACK})) begin
      bit_cnt_d = bit_cnt_q + 2'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Output logic. Line drives decode the asynchronously reset state
  // registers, so reset releases both lines immediately.
  // --------------------------------------------------------------------------
  always_comb begin
    w_clk_low = w_in_frame && ((bit_cnt_q == 2'd1) || (bit_cnt_q == 2'd2));
    w_dat_low = (state_q == S_ACK);
    ready     = (state_q == S_IDLE);
  end

  assign PS2_CLK    = w_clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT    = w_dat_low ? 1'b0 : 1'bz;
  assign buffer     = buffer_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign abort      = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_rx
// Purpose  : Self-checking bench for ps2_rx. A host model drives frames on
//            the open-drain bus; expected events are queued when a frame is
//            launched and compared when the DUT pulses valid/parity_err/abort.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_rx;

  localparam int RTS_QUARTERS = 2;

  localparam logic [2:0] EV_VALID = 3'b100;
  localparam logic [2:0] EV_PERR  = 3'b010;
  localparam logic [2:0] EV_ABORT = 3'b001;

  typedef struct packed {
    logic [2:0] ev;
    logic [7:0] bval;
  } sb_t;

  logic       clk          = 1'b0;
  logic       rst_n        = 1'b0;
  logic       inhibit      = 1'b0;
  logic       host_clk_low = 1'b0;
  logic       host_dat_low = 1'b0;
  logic [7:0] buffer;
  logic       valid;
  logic       parity_err;
  logic       abort;
  logic       ready;
  wire        ps2_clk;
  wire        ps2_dat;

  assign ps2_clk = host_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = host_dat_low ? 1'b0 : 1'bz;
  pullup (ps2_clk);
  pullup (ps2_dat);

  ps2_rx #(.RTS_QUARTERS(RTS_QUARTERS)) dut (
    .clock_quarter (clk),
    .reset         (rst_n),
    .inhibit       (inhibit),
    .buffer        (buffer),
    .valid         (valid),
    .parity_err    (parity_err),
    .abort         (abort),
    .ready         (ready),
    .PS2_CLK       (ps2_clk),
    .PS2_DAT       (ps2_dat)
  );

  always #5 clk = ~clk;

  int         n_vec      = 0;
  int         n_err      = 0;
  sb_t        sb_q[$];
  sb_t        mon_e;
  logic [7:0] exp_buf    = 8'h00;
  logic       ready_next = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] v);
    return ~^v;
  endfunction

  task automatic expect_ev(input logic [2:0] ev, input logic [7:0] b);
    sb_t e;
    e.ev   = ev;
    e.bval = b;
    sb_q.push_back(e);
  endtask

  // Event monitor: every output pulse must match the head of the queue,
  // the DUT must be in DELAY (not ready) then return to IDLE next quarter.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ready_next) begin
          chk("ready_after_event", 32'(ready), 1);
          ready_next = 1'b0;
        end
        if (valid || parity_err || abort) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_event", {29'd0, valid, parity_err, abort}, 0);
          end else begin
            mon_e = sb_q.pop_front();
            chk("event_kind", {29'd0, valid, parity_err, abort}, {29'd0, mon_e.ev});
            chk("buffer", 32'(buffer), 32'(mon_e.bval));
            chk("ready_in_delay", 32'(ready), 0);
          end
          ready_next = 1'b1;
        end
      end
    end
  end

  // Host model for one frame. Bits change after each device clock fall;
  // optionally holds the clock low after pulse abort_pulse rises, withdraws
  // the request right after START, or raises inhibit at pulse inh_pulse.
  task automatic host_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int abort_pulse, input logic withdraw, input int inh_pulse,
                            output int pulses, output int quarters, output logic ack_low);
    logic [10:0] bits;
    int          q;
    logic        prev;
    logic        cur;
    logic        rel_chk;
    bits     = {stp, par, d, 1'b0};
    pulses   = 0;
    quarters = 0;
    ack_low  = 1'b0;
    prev     = 1'b1;
    rel_chk  = 1'b0;
    q        = 0;
    host_dat_low = 1'b1;
    do begin
      @(negedge clk);
      q++;
    end while (ready && q < 50);
    chk("rts_quarters", q, RTS_QUARTERS);
    if (withdraw) host_dat_low = 1'b0;
    for (int t = 0; t < 80; t++) begin
      if (ready) begin
        quarters = t;
        break;
      end
      if (rel_chk) begin
        host_clk_low = 1'b0;
        host_dat_low = 1'b0;
        #1;
        chk("abort_clk_released", 32'(ps2_clk), 1);
        chk("abort_dat_released", 32'(ps2_dat), 1);
        rel_chk = 1'b0;
        prev    = 1'b1;
      end else begin
        cur = ps2_clk;
        if (prev && !cur) begin
          pulses++;
          if (pulses == 12) ack_low = (ps2_dat === 1'b0);
          if (!withdraw) host_dat_low = (pulses <= 11) ? ~bits[pulses-1] : 1'b0;
          if (pulses == inh_pulse) inhibit = 1'b1;
        end
        if (abort_pulse != 0 && pulses == abort_pulse && !prev && cur) begin
          host_clk_low = 1'b1;
          rel_chk      = 1'b1;
        end
        prev = cur;
      end
      @(negedge clk);
    end
    if (quarters == 0) chk("frame_timeout", 32'(ready), 1);
    host_clk_low = 1'b0;
    host_dat_low = 1'b0;
    inhibit      = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int         p;
    int         qq;
    int         bad;
    int         q;
    logic       ak;
    logic       prev;
    logic       cur;
    logic [7:0] d;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready",   32'(ready), 1);
    chk("rst_valid",   32'(valid), 0);
    chk("rst_perr",    32'(parity_err), 0);
    chk("rst_abort",   32'(abort), 0);
    chk("rst_buffer",  32'(buffer), 0);
    chk("rst_ps2_clk", 32'(ps2_clk), 1);
    chk("rst_ps2_dat", 32'(ps2_dat), 1);
    rst_n = 1'b1;

    // Good frame 0xED with correct odd parity
    exp_buf = 8'hED;
    expect_ev(EV_VALID, exp_buf);
    host_frame(8'hED, odd_par(8'hED), 1'b1, 0, 1'b0, 0, p, qq, ak);
    chk("ed_pulses", p, 12);
    chk("ed_quarters", qq, 49);
    chk("ed_ack", 32'(ak), 1);

    // Bad parity 0xF4/1: ACK still driven, buffer kept
    expect_ev(EV_PERR, exp_buf);
    host_frame(8'hF4, 1'b1, 1'b1, 0, 1'b0, 0, p, qq, ak);
    chk("f4_pulses", p, 12);
    chk("f4_ack", 32'(ak), 1);

    // Random good bytes; inhibit raised mid-frame on the first
    for (int i = 0; i < 3; i++) begin
      d       = 8'($urandom_range(0, 255));
      exp_buf = d;
      expect_ev(EV_VALID, exp_buf);
      host_frame(d, odd_par(d), 1'b1, 0, 1'b0, (i == 0) ? 3 : 0, p, qq, ak);
      chk("rnd_quarters", qq, 49);
    end

    // Host holds clock low during data bit 4 (pulse 6)
    expect_ev(EV_ABORT, exp_buf);
    host_frame(8'h96, odd_par(8'h96), 1'b1, 6, 1'b0, 0, p, qq, ak);
    chk("abort_pulses", p, 6);
    chk("abort_quarters", qq, 25);

    // Host withdraws request before the start sample
    host_frame(8'h00, 1'b0, 1'b1, 0, 1'b1, 0, p, qq, ak);
    chk("withdraw_pulses", p, 1);
    chk("withdraw_quarters", qq, 5);

    // Stop bit 0: framing error, no ACK bit
    expect_ev(EV_PERR, exp_buf);
    host_frame(8'h3C, odd_par(8'h3C), 1'b0, 0, 1'b0, 0, p, qq, ak);
    chk("stop0_pulses", p, 11);
    chk("stop0_quarters", qq, 45);

    // Inhibit blocks request-to-send
    inhibit      = 1'b1;
    host_dat_low = 1'b1;
    bad          = 0;
    repeat (10) begin
      @(negedge clk);
      if (!ready || ps2_clk !== 1'b1) bad++;
    end
    chk("inhibit_idle", bad, 0);
    inhibit = 1'b0;
    exp_buf = 8'hA7;
    expect_ev(EV_VALID, exp_buf);
    host_frame(8'hA7, odd_par(8'hA7), 1'b1, 0, 1'b0, 0, p, qq, ak);
    chk("inh_quarters", qq, 49);

    // Reset asserted while the device drives the parity-bit clock pulse
    host_dat_low = 1'b1;
    q = 0;
    do begin
      @(negedge clk);
      q++;
    end while (ready && q < 50);
    p    = 0;
    prev = 1'b1;
    for (int t = 0; t < 60 && p < 10; t++) begin
      cur = ps2_clk;
      if (prev && !cur) p++;
      prev = cur;
      if (p < 10) @(negedge clk);
    end
    chk("parity_reached", p, 10);
    host_dat_low = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ps2_clk", 32'(ps2_clk), 1);
    chk("mid_rst_ps2_dat", 32'(ps2_dat), 1);
    chk("mid_rst_outputs", {29'd0, valid, parity_err, abort}, 0);
    chk("mid_rst_buffer", 32'(buffer), 0);
    chk("mid_rst_ready", 32'(ready), 1);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    exp_buf = 8'h00;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready), 1);

    // RTS qualification restarts from zero after reset
    exp_buf = 8'h5A;
    expect_ev(EV_VALID, exp_buf);
    host_frame(8'h5A, odd_par(8'h5A), 1'b1, 0, 1'b0, 0, p, qq, ak);
    chk("post_rst_pulses", p, 12);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
